split_data: RTL and testbench

SPLIT_DATA -- requirements
Module: split_data

---
 rtl/split_data.sv | 138 +++++++++++++
 tb/tb_split_data.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/split_data.sv
// split_data: unpacks OSIZE-bit memory words (first pixel in the MSBs) into a stream of ISIZE-bit pixels.
// MODE "ONCE" keeps the bitstream continuous; "LINE" restarts every line at the MSB of a fresh word.
module split_data #(
  parameter int    ISIZE = 24,
  parameter int    OSIZE = 256,
  parameter string MODE  = "ONCE"
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ialign,
  input  logic             ivalid,
  output logic             iready,
  input  logic [OSIZE-1:0] idata,
  input  logic             ilast,
  input  logic [15:0]      iline_len,
  output logic             ovalid,
  input  logic             oready,
  output logic [ISIZE-1:0] odata,
  output logic             olast,
  output logic             oerr
);
  // state | meaning
  // RUN   | extracting pixels, loading words on demand
  // DRAIN | line finished before its ilast word; discarding words up to and including ilast

  localparam int            BW        = OSIZE + ISIZE;
  localparam int            CW        = $clog2(BW + 1);
  localparam logic [CW-1:0] C_I       = CW'(ISIZE);
  localparam logic [CW-1:0] C_2I      = CW'(2 * ISIZE);
  localparam logic [CW-1:0] C_O       = CW'(OSIZE);
  localparam bit            LINE_MODE = (MODE == "LINE");

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t           r_state, w_state_nx;
  logic [BW-1:0]    r_buf;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_pcnt;
  logic             r_lastin;
  logic             r_ovalid;
  logic             r_olast;
  logic             r_oerr;
  logic [ISIZE-1:0] r_odata;

  logic             w_ext, w_eol, w_short, w_acc, w_iready;
  logic [CW-1:0]    w_cnt_ext;
  logic [15:0]      w_len_m1;
  logic [BW-1:0]    w_buf_ext, w_keep_mask, w_word, w_buf_ld;

  always_comb begin
    w_len_m1    = iline_len - 16'd1;
    w_ext       = (r_state == S_RUN) && (r_cnt >= C_I) && (!r_ovalid || oready) && !ialign;
    w_eol       = LINE_MODE && w_ext && (r_pcnt == w_len_m1);
    w_short     = LINE_MODE && (r_state == S_RUN) && r_lastin && (r_cnt < C_I) && !ialign;
    w_cnt_ext   = w_ext ? (r_cnt - C_I) : r_cnt;
    w_buf_ext   = w_ext ? (r_buf << ISIZE) : r_buf;
    // Only the top w_cnt_ext bits are live; anything below is stale after a line clear.
    w_keep_mask = ~({BW{1'b1}} >> w_cnt_ext);
    w_word      = {idata, {ISIZE{1'b0}}} >> w_cnt_ext;
    w_buf_ld    = (w_buf_ext & w_keep_mask) | w_word;

    w_iready = 1'b0;
    if (ialign)
      w_iready = 1'b0;
    else if (r_state == S_DRAIN)
      w_iready = 1'b1;
    else
      // Once the ilast word is in, the next line must not be appended to this one.
      w_iready = ((r_cnt < C_I) || ((r_cnt < C_2I) && w_ext)) && !w_eol
                 && !(LINE_MODE && r_lastin);
    w_acc = ivalid && w_iready;

    w_state_nx = r_state;
    if (ialign)
      w_state_nx = S_RUN;
    else if ((r_state == S_DRAIN) && w_acc && ilast)
      w_state_nx = S_RUN;
    else if (w_eol && !r_lastin)
      w_state_nx = S_DRAIN;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_buf    <= '0;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_lastin <= 1'b0;
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_olast  <= 1'b0;
      r_oerr   <= 1'b0;
    end else if (ialign) begin
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_lastin <= 1'b0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_oerr   <= 1'b0;
    end else begin
      r_oerr <= w_short;
      if (w_ext) begin
        r_odata  <= r_buf[BW-1 -: ISIZE];
        r_ovalid <= 1'b1;
        r_olast  <= w_eol;
      end else if (oready) begin
        r_ovalid <= 1'b0;
        r_olast  <= 1'b0;
      end
      if ((r_state == S_DRAIN) || w_eol || w_short) begin
        r_cnt    <= '0;
        r_pcnt   <= '0;
        r_lastin <= 1'b0;
      end else begin
        if (LINE_MODE && w_ext) r_pcnt <= r_pcnt + 16'd1;
        if (w_acc) begin
          r_buf <= w_buf_ld;
          r_cnt <= w_cnt_ext + C_O;
          if (LINE_MODE && ilast) r_lastin <= 1'b1;
        end else begin
          r_buf <= w_buf_ext;
          r_cnt <= w_cnt_ext;
        end
      end
    end
  end

  assign iready = w_iready;
  assign ovalid = r_ovalid;
  assign odata  = r_odata;
  assign olast  = r_olast;
  assign oerr   = r_oerr;

endmodule

// File: tb/tb_split_data.sv
// Bench for split_data: one ONCE and one LINE instance, pixel scoreboard fed from a bit-exact stream model.
// A table of line cases drives the LINE instance; hand sequences cover stalls, ialign and mid-word reset.
module tb_split_data;
  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         ialign = 1'b0;
  logic         oready = 1'b0;
  logic         ilast = 1'b0;
  logic         ivalid_o = 1'b0, ivalid_l = 1'b0;
  logic [255:0] idata = '0;
  logic [15:0]  iline_len = 16'd12;
  logic         iready_o, iready_l, ovalid_o, ovalid_l, olast_o, olast_l, oerr_o, oerr_l;
  logic [23:0]  odata_o, odata_l;

  always #5 clock = ~clock;

  split_data #(.ISIZE(24), .OSIZE(256), .MODE("ONCE")) u_once (
    .clock(clock), .rst_n(rst_n), .ialign(ialign), .ivalid(ivalid_o), .iready(iready_o),
    .idata(idata), .ilast(ilast), .iline_len(iline_len), .ovalid(ovalid_o), .oready(oready),
    .odata(odata_o), .olast(olast_o), .oerr(oerr_o));

  split_data #(.ISIZE(24), .OSIZE(256), .MODE("LINE")) u_line (
    .clock(clock), .rst_n(rst_n), .ialign(ialign), .ivalid(ivalid_l), .iready(iready_l),
    .idata(idata), .ilast(ilast), .iline_len(iline_len), .ovalid(ovalid_l), .oready(oready),
    .odata(odata_l), .olast(olast_l), .oerr(oerr_l));

  typedef struct { logic [23:0] data; logic last; } exp_t;
  typedef struct { int len; int nwords; int exp_pix; int exp_olast; int exp_oerr; } vec_t;

  exp_t        q_o[$], q_l[$];
  vec_t        tbl[8];
  int          n_vec = 0, n_err = 0, cyc = 0;
  int          n_x_o = 0, t_first = 0, t_last = 0;
  int          n_olast_l = 0, n_oerr_l = 0, n_oerr_o = 0;
  bit          rnd_ready = 1'b0;
  logic        s_ir_o, s_ir_l, s_ov_o;
  logic        st_o = 1'b0, st_l = 1'b0;
  logic [23:0] hold_o, hold_l;

  function automatic logic [23:0] pix_val(input int seed, input int p);
    int v;
    v = seed * 1000003 + p * 4099 + 7;
    return v[23:0];
  endfunction

  // Word w of a stream whose pixels are pix_val(seed, 0), pix_val(seed, 1), ... packed MSB first.
  function automatic logic [255:0] make_word(input int seed, input int w);
    logic [255:0] r;
    logic [23:0]  pv;
    int           g;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      g = w * 256 + i;
      pv = pix_val(seed, g / 24);
      r[255 - i] = pv[23 - (g % 24)];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic push_line(input bit sel, input int seed, input int n, input bit with_last);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = pix_val(seed, k);
      e.last = with_last && (k == n - 1);
      if (sel) q_l.push_back(e); else q_o.push_back(e);
    end
  endtask

  // One clock: sample and score at the falling edge, then advance past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    cyc++;
    s_ir_o = iready_o;
    s_ir_l = iready_l;
    s_ov_o = ovalid_o;
    if (ovalid_o && oready) begin
      if (q_o.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL once_extra_pixel: got %0h, want no pixel", odata_o);
      end else begin
        e = q_o.pop_front();
        chk("once_data", odata_o, e.data);
        chk("once_last", olast_o, e.last);
        n_x_o++;
        if (n_x_o == 1) t_first = cyc;
        t_last = cyc;
      end
    end
    if (ovalid_l && oready) begin
      if (q_l.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL line_extra_pixel: got %0h, want no pixel", odata_l);
      end else begin
        e = q_l.pop_front();
        chk("line_data", odata_l, e.data);
        chk("line_last", olast_l, e.last);
        if (olast_l) n_olast_l++;
      end
    end
    if (st_o && ovalid_o) chk("once_hold", odata_o, hold_o);
    if (st_l && ovalid_l) chk("line_hold", odata_l, hold_l);
    st_o = ovalid_o && !oready;  hold_o = odata_o;
    st_l = ovalid_l && !oready;  hold_l = odata_l;
    if (oerr_o) n_oerr_o++;
    if (oerr_l) n_oerr_l++;
    @(posedge clock);
    #1;
    if (rnd_ready) oready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input bit sel, input logic [255:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    idata = d;
    ilast = last;
    if (sel) ivalid_l = 1'b1; else ivalid_o = 1'b1;
    for (int k = 0; k < 3000 && !ok; k++) begin
      cycle();
      ok = sel ? s_ir_l : s_ir_o;
    end
    ivalid_l = 1'b0;
    ivalid_o = 1'b0;
    ilast    = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: iready stayed 0, want 1");
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 6000 && (q_o.size() != 0 || q_l.size() != 0); k++) cycle();
    chk("drain_once", q_o.size(), 0);
    chk("drain_line", q_l.size(), 0);
    repeat (6) cycle();
  endtask

  initial begin
    //           len nwords pix olast oerr
    tbl[0] = '{12, 2, 12, 1, 0};
    tbl[1] = '{12, 3, 12, 1, 0};
    tbl[2] = '{20, 1, 10, 0, 1};
    tbl[3] = '{11, 2, 11, 1, 0};
    tbl[4] = '{ 5, 3,  5, 1, 0};
    tbl[5] = '{30, 2, 21, 0, 1};
    tbl[6] = '{32, 3, 32, 1, 0};
    tbl[7] = '{ 1, 1,  1, 1, 0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ovalid_o", ovalid_o, 0);  chk("rst_odata_o", odata_o, 0);
    chk("rst_olast_o", olast_o, 0);    chk("rst_oerr_o", oerr_o, 0);
    chk("rst_ovalid_l", ovalid_l, 0);  chk("rst_odata_l", odata_l, 0);
    chk("rst_olast_l", olast_l, 0);    chk("rst_oerr_l", oerr_l, 0);
    @(posedge clock);
    #1;
    rst_n  = 1'b1;
    oready = 1'b1;
    cycle();

    // Continuous stream: 3 words -> 32 pixels, back to back.
    push_line(0, 30, 32, 0);
    n_x_o = 0;
    for (int w = 0; w < 3; w++) send_word(0, make_word(30, w), 0);
    wait_idle();
    chk("once_count", n_x_o, 32);
    chk("once_gapless", t_last - t_first, 31);

    // Random backpressure over 100 words; 1066 whole pixels, 16 bits left over.
    rnd_ready = 1'b1;
    push_line(0, 40, 1066, 0);
    for (int w = 0; w < 100; w++) send_word(0, make_word(40, w), 0);
    wait_idle();
    rnd_ready = 1'b0;
    oready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      iline_len = 16'(tbl[i].len);
      push_line(1, 10 + i, tbl[i].exp_pix, tbl[i].exp_olast != 0);
      n_olast_l = 0;
      n_oerr_l  = 0;
      for (int w = 0; w < tbl[i].nwords; w++)
        send_word(1, make_word(10 + i, w), w == tbl[i].nwords - 1);
      wait_idle();
      chk($sformatf("line%0d_olast_cnt", i), n_olast_l, tbl[i].exp_olast);
      chk($sformatf("line%0d_oerr_cnt", i), n_oerr_l, tbl[i].exp_oerr);
    end

    // ialign flushes residue and a stalled output; the word offered with it is dropped.
    oready = 1'b0;
    ialign = 1'b1;
    cycle();
    ialign = 1'b0;
    send_word(0, make_word(50, 0), 0);
    cycle();
    chk("lat_not_early", s_ov_o, 0);
    cycle();
    chk("lat_first", s_ov_o, 1);
    repeat (3) cycle();
    idata    = make_word(51, 0);
    ivalid_o = 1'b1;
    ialign   = 1'b1;
    cycle();
    chk("align_iready", s_ir_o, 0);
    ialign   = 1'b0;
    ivalid_o = 1'b0;
    cycle();
    chk("align_ovalid", s_ov_o, 0);
    oready = 1'b1;
    push_line(0, 52, 10, 0);
    send_word(0, make_word(52, 0), 0);
    wait_idle();

    // Reset in the middle of a word discards everything buffered.
    oready = 1'b0;
    send_word(0, make_word(60, 0), 0);
    repeat (3) cycle();
    chk("pre_rst_ovalid", s_ov_o, 1);
    rst_n = 1'b0;
    @(negedge clock);
    chk("rst_mid_ovalid", ovalid_o, 0);
    chk("rst_mid_odata", odata_o, 0);
    @(posedge clock);
    #1;
    rst_n  = 1'b1;
    oready = 1'b1;
    repeat (4) cycle();
    push_line(0, 61, 10, 0);
    send_word(0, make_word(61, 0), 0);
    wait_idle();
    chk("once_oerr_cnt", n_oerr_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
